// File: rtl/spec_reg_sequencer_pkg.sv
// Shared control-unit definitions: instruction classes, flags-register commands,
// sequencer states and flag bit positions.
package spec_reg_sequencer_pkg;

    localparam int unsigned FlagWidth = 5;

    // Bit positions inside the {N,Z,C,V,mode} flags word
    localparam int unsigned FlagN    = 4;
    localparam int unsigned FlagZ    = 3;
    localparam int unsigned FlagC    = 2;
    localparam int unsigned FlagV    = 1;
    localparam int unsigned FlagMode = 0;

    typedef enum logic [2:0] {
        ClsNone    = 3'd0,
        ClsShift   = 3'd1,
        ClsArith   = 3'd2,
        ClsMove    = 3'd3,
        ClsOvf     = 3'd4,
        ClsSwi     = 3'd5,
        ClsReturn  = 3'd6,
        ClsBiosOff = 3'd7
    } instr_class_e;

    typedef enum logic [3:0] {
        CmdNop        = 4'd0,
        CmdShift      = 4'd1,
        CmdArith      = 4'd2,
        CmdMove       = 4'd3,
        CmdOvf        = 4'd4,
        CmdModeToggle = 4'd5,
        CmdBiosOff    = 4'd7
    } update_cmd_e;

    typedef enum logic [2:0] {
        StIdle      = 3'd0,
        StSwiToggle = 3'd1,
        StSwiRedir  = 3'd2,
        StRetToggle = 3'd3,
        StRetRedir  = 3'd4
    } seq_state_e;

    // Flag-update command for the single-cycle ALU-style classes
    function automatic update_cmd_e alu_cmd(instr_class_e cls);
        update_cmd_e cmd;
        cmd = CmdNop;
        case (cls)
            ClsShift: cmd = CmdShift;
            ClsArith: cmd = CmdArith;
            ClsMove:  cmd = CmdMove;
            ClsOvf:   cmd = CmdOvf;
            default:  cmd = CmdNop;
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/spec_reg_sequencer.sv
// Drives the flags-register update_mode port and runs the SWI entry/return
// sequences (capture, mode toggle, redirect handshake with fetch).
module spec_reg_sequencer
    import spec_reg_sequencer_pkg::*;
#(
    parameter int unsigned SWI_WAIT_MAX = 15
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 instr_valid,
    input  logic [2:0]           instr_class,
    input  logic [FlagWidth-1:0] flags_in,
    input  logic                 is_bios,
    input  logic                 redirect_ack,
    output logic [3:0]           update_mode,
    output logic                 stall,
    output logic                 redirect_req,
    output logic                 redirect_sel,
    output logic [FlagWidth-1:0] saved_flags,
    output logic                 seq_err
);

    seq_state_e           state_q, state_d;
    logic [3:0]           wait_cnt_q, wait_cnt_d;
    logic [3:0]           update_mode_q, update_mode_d;
    logic                 stall_q, stall_d;
    logic                 redirect_req_q, redirect_req_d;
    logic                 redirect_sel_q, redirect_sel_d;
    logic [FlagWidth-1:0] saved_flags_q, saved_flags_d;
    logic                 seq_err_q, seq_err_d;

    instr_class_e cls;
    logic         accept;
    logic         mode_bit;
    logic         in_redir;
    logic         wait_expired;

    assign cls          = instr_class_e'(instr_class);
    assign accept       = (state_q == StIdle) && instr_valid;
    assign mode_bit     = flags_in[FlagMode];
    assign in_redir     = (state_q == StSwiRedir) || (state_q == StRetRedir);
    // Last permitted wait cycle: no ack now means the handshake is abandoned
    assign wait_expired = (wait_cnt_q == 4'(SWI_WAIT_MAX - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= StIdle;
            wait_cnt_q     <= 4'd0;
            update_mode_q  <= 4'd0;
            stall_q        <= 1'b0;
            redirect_req_q <= 1'b0;
            redirect_sel_q <= 1'b0;
            saved_flags_q  <= '0;
            seq_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            update_mode_q  <= update_mode_d;
            stall_q        <= stall_d;
            redirect_req_q <= redirect_req_d;
            redirect_sel_q <= redirect_sel_d;
            saved_flags_q  <= saved_flags_d;
            seq_err_q      <= seq_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (cls == ClsSwi && !mode_bit) begin
                        state_d = StSwiToggle;
                    end else if (cls == ClsReturn && mode_bit) begin
                        state_d = StRetToggle;
                    end
                end
            end
            StSwiToggle: state_d = StSwiRedir;
            StRetToggle: state_d = StRetRedir;
            StSwiRedir, StRetRedir: begin
                if (redirect_ack || wait_expired) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are registered from the next state so every response lands one
    // cycle after the event that caused it.
    always_comb begin
        update_mode_d  = CmdNop;
        seq_err_d      = 1'b0;
        saved_flags_d  = saved_flags_q;
        wait_cnt_d     = 4'd0;
        stall_d        = (state_d != StIdle);
        redirect_req_d = (state_d == StSwiRedir) || (state_d == StRetRedir);
        redirect_sel_d = (state_d == StRetRedir);

        if (accept) begin
            unique case (cls)
                ClsShift, ClsArith, ClsMove, ClsOvf: update_mode_d = alu_cmd(cls);
                ClsSwi: begin
                    if (mode_bit) begin
                        seq_err_d = 1'b1;
                    end else begin
                        saved_flags_d = flags_in;
                    end
                end
                ClsReturn: begin
                    if (!mode_bit) begin
                        seq_err_d = 1'b1;
                    end
                end
                ClsBiosOff: begin
                    if (is_bios) begin
                        update_mode_d = CmdBiosOff;
                    end
                end
                ClsNone: update_mode_d = CmdNop;
                default: update_mode_d = CmdNop;
            endcase
        end

        if (state_d == StSwiToggle || state_d == StRetToggle) begin
            update_mode_d = CmdModeToggle;
        end

        if (in_redir && !redirect_ack) begin
            if (wait_expired) begin
                seq_err_d = 1'b1;
            end else begin
                wait_cnt_d = wait_cnt_q + 4'd1;
            end
        end
    end

    assign update_mode  = update_mode_q;
    assign stall        = stall_q;
    assign redirect_req = redirect_req_q;
    assign redirect_sel = redirect_sel_q;
    assign saved_flags  = saved_flags_q;
    assign seq_err      = seq_err_q;

endmodule
